attn_flash_sched: RTL
=====================

// Module: attn_flash_sched
// PURPOSE
//  Tiled flash-attention sequencer; next generation of the single-tile attention controller. Drives the SA_wrapper
//  and safe_softmax through Q*K^T -> scale -> online softmax -> P*V for any sequence length up to MAX_SEQ_TILES*SA.
//  Per-row running max/sum (m,l) kept across K tiles; optional causal mode skips K tiles above the diagonal.
//  Sits between the MHA top-level and the SA_wrapper/softmax; issues tile indices only, no matrix datapath.
// PARAMETERS
//  SA            16  SA edge (rows = cols); tile size
//  D_K           128 head dimension; multiple of SA; DK_TILES = D_K/SA
//  MAX_SEQ_TILES 8   max sequence tiles; TW = $clog2(MAX_SEQ_TILES+1)
//  M_W           8   running-max width (signed)
//  L_W           16  running-sum width (unsigned)
// PORTS
//  I_CLK          in  1     clock
//  I_ASYN_RST     in  1     async reset, active-high
//  I_ATTN_START   in  1     start pulse; sampled only in IDLE
//  I_SEQ_TILES    in  TW    sequence length in tiles; latched on start
//  I_CAUSAL       in  1     causal mask mode; latched on start
//  O_SA_START     out 1     one-cycle SA op request
//  O_SA_OP        out 2     0=QK 1=SCALE 2=PV; held from ISSUE until I_SA_VLD
//  O_SA_Q_TILE    out TW-1  current query tile qi
//  O_SA_K_TILE    out TW-1  current key/value tile kj
//  O_SA_DK_TILE   out $clog2(DK_TILES)  D_K slice for PV
//  O_SA_ACC       out 1     PV accumulates into output buffer (kj!=0)
//  O_M_DIM        out 8     SA inner dimension: D_K for QK, SA otherwise
//  I_SA_VLD       in  1     one-cycle SA result strobe
//  O_SM_START     out 1     level; held high while a softmax row is in flight
//  O_SM_ROW       out $clog2(SA)  row of scaled tile fed to softmax
//  O_SM_M_IN      out M_W   m[row];  O_SM_L_IN  out L_W  l[row]
//  I_SM_VLD       in  1     one-cycle softmax row done
//  I_SM_M_OUT     in  M_W   updated max;  I_SM_L_OUT  in  L_W  updated sum
//  O_WB_VLD       out 1     one-cycle: output tile (O_SA_Q_TILE,O_SA_DK_TILE) final, write back
//  O_BUSY         out 1     high from accepted start to DONE
//  O_DONE         out 1     one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, O_M_DIM=D_K, m[*]=M_INIT(8'h80), l[*]=0, counters 0.
//  States: IDLE->(start) CLR_ML->QK_ISS->QK_WT->SC_ISS->SC_WT->SM_RUN->PV_ISS->PV_WT->[WB]->...->DONE->IDLE.
//  *_ISS: exactly one cycle, O_SA_START=1, O_SA_OP/O_M_DIM set. *_WT: wait I_SA_VLD; I_SA_VLD in other states ignored.
//  SM_RUN: O_SM_START=1 from row 0; on I_SM_VLD write m/l[row], row++; after row SA-1 -> PV_ISS with dk=0.
//  PV_WT on vld: dk<DK_TILES-1 -> dk++, PV_ISS; else kj++ and QK_ISS, or if kj was last -> WB.
//  Last kj = causal ? qi : seq_tiles-1. WB: DK_TILES cycles, O_WB_VLD=1 each, dk 0..DK_TILES-1; then qi++, CLR_ML,
//  or DONE if qi was seq_tiles-1. CLR_ML: one cycle, m=M_INIT, l=0, kj=0. DONE: O_DONE=1 one cycle, O_BUSY drops same cycle.
//  seq_tiles=0 -> straight to DONE (no SA traffic); seq_tiles>MAX_SEQ_TILES clamped to MAX_SEQ_TILES.
//  I_ATTN_START while busy ignored; I_SEQ_TILES/I_CAUSAL changes after start ignored.
//  Async reset mid-op: immediate return to reset values; no WB or DONE emitted.
//  Simultaneous I_SA_VLD and I_SM_VLD cannot both matter: each consumed only in its own wait state.
//  Op count per q tile: K=(kj_last+1); SA ops = K*(2+DK_TILES); softmax rows = K*SA.
// STRUCTURE
//  attn_pkg: sa_op_e {OP_QK,OP_SCALE,OP_PV}, sched_state_e (one-hot), M_INIT, OP_W.
//  Sub-module attn_ml_regfile: SA-entry m/l storage, sync write on I_SM_VLD, async read by row, bulk clear.
//  Top: FSM + qi/kj/dk/row counters + latched config.
// TESTING
//  SEQ=1, non-causal, SA_VLD 3 cycles after each start -> ops QK,SCALE,16 SM rows,8 PV (ACC=0), 8 WB, one DONE.
//  SEQ=3, non-causal -> per qi kj=0..2, 30 SA ops/qi, ACC=1 for kj>0, total 90 ops, 24 WB pulses.
//  SEQ=3, causal -> qi0:1 kj, qi1:2, qi2:3; 60 SA ops total; no kj>qi ever issued.
//  SM_OUT m=5,l=300 for row 4 -> O_SM_M_IN=5,L_IN=300 at next kj row 4; 8'h80/0 after CLR_ML.
//  SEQ=0 -> DONE 2 cycles after start, O_SA_START never high; SEQ=15 clamped to 8.
//  Reset asserted in PV_WT; start re-issued while busy; stray SA_VLD in SM_RUN -> reset values, start ignored, stray ignored.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types and constants for the tiled flash-attention scheduler.
// SA opcodes, one-hot FSM states and the running-max reset value.
package attn_pkg;

    localparam int OP_W = 2;
    localparam logic [7:0] M_INIT = 8'h80;

    typedef enum logic [OP_W-1:0] {
        OP_QK    = 2'd0,
        OP_SCALE = 2'd1,
        OP_PV    = 2'd2
    } sa_op_e;

    typedef enum logic [10:0] {
        StIdle  = 11'b000_0000_0001,
        StClrMl = 11'b000_0000_0010,
        StQkIss = 11'b000_0000_0100,
        StQkWt  = 11'b000_0000_1000,
        StScIss = 11'b000_0001_0000,
        StScWt  = 11'b000_0010_0000,
        StSmRun = 11'b000_0100_0000,
        StPvIss = 11'b000_1000_0000,
        StPvWt  = 11'b001_0000_0000,
        StWb    = 11'b010_0000_0000,
        StDone  = 11'b100_0000_0000
    } sched_state_e;

endpackage

// File: rtl/attn_ml_regfile.sv
// Per-row running max (m) and running sum (l) storage for one query tile.
// Synchronous write, asynchronous read, single-cycle bulk clear.
module attn_ml_regfile
    import attn_pkg::*;
#(
    parameter int unsigned SA  = 16,
    parameter int unsigned M_W = 8,
    parameter int unsigned L_W = 16,
    parameter logic [M_W-1:0] M_RST = M_W'(M_INIT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [$clog2(SA)-1:0]  row,
    input  logic [M_W-1:0]         m_wr,
    input  logic [L_W-1:0]         l_wr,
    output logic [M_W-1:0]         m_rd,
    output logic [L_W-1:0]         l_rd
);

    logic [M_W-1:0] m_q [SA];
    logic [L_W-1:0] l_q [SA];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SA); i++) begin
                m_q[i] <= M_RST;
                l_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(SA); i++) begin
                m_q[i] <= M_RST;
                l_q[i] <= '0;
            end
        end else if (we) begin
            m_q[row] <= m_wr;
            l_q[row] <= l_wr;
        end
    end

    assign m_rd = m_q[row];
    assign l_rd = l_q[row];

endmodule

// File: rtl/attn_flash_sched.sv
// Tiled flash-attention sequencer: walks q tiles, k tiles and D_K slices, issuing SA ops and
// softmax rows while keeping per-row running max/sum across k tiles. Tile indices only.
module attn_flash_sched
    import attn_pkg::*;
#(
    parameter int unsigned SA            = 16,
    parameter int unsigned D_K           = 128,
    parameter int unsigned MAX_SEQ_TILES = 8,
    parameter int unsigned M_W           = 8,
    parameter int unsigned L_W           = 16,
    localparam int unsigned TW       = $clog2(MAX_SEQ_TILES + 1),
    localparam int unsigned DK_TILES = D_K / SA,
    localparam int unsigned DKW      = $clog2(DK_TILES),
    localparam int unsigned RW       = $clog2(SA)
) (
    input  logic            I_CLK,
    input  logic            I_ASYN_RST,
    input  logic            I_ATTN_START,
    input  logic [TW-1:0]   I_SEQ_TILES,
    input  logic            I_CAUSAL,
    output logic            O_SA_START,
    output logic [OP_W-1:0] O_SA_OP,
    output logic [TW-2:0]   O_SA_Q_TILE,
    output logic [TW-2:0]   O_SA_K_TILE,
    output logic [DKW-1:0]  O_SA_DK_TILE,
    output logic            O_SA_ACC,
    output logic [7:0]      O_M_DIM,
    input  logic            I_SA_VLD,
    output logic            O_SM_START,
    output logic [RW-1:0]   O_SM_ROW,
    output logic [M_W-1:0]  O_SM_M_IN,
    output logic [L_W-1:0]  O_SM_L_IN,
    input  logic            I_SM_VLD,
    input  logic [M_W-1:0]  I_SM_M_OUT,
    input  logic [L_W-1:0]  I_SM_L_OUT,
    output logic            O_WB_VLD,
    output logic            O_BUSY,
    output logic            O_DONE
);

    localparam logic [7:0] MDIM_QK = 8'(D_K);
    localparam logic [7:0] MDIM_SA = 8'(SA);

    sched_state_e  state_q;
    sa_op_e        sa_op_q;
    logic [TW-1:0] seq_q;
    logic          causal_q;
    logic [TW-2:0] qi_q, kj_q;
    logic [DKW-1:0] dk_q;
    logic [RW-1:0] row_q;
    logic [7:0]    m_dim_q;
    logic          sa_start_q, sm_start_q, wb_vld_q, busy_q, done_q;

    logic [TW-1:0] seq_clamp;
    logic          qi_last, kj_last, dk_last, row_last;

    assign seq_clamp = (I_SEQ_TILES > TW'(MAX_SEQ_TILES)) ? TW'(MAX_SEQ_TILES) : I_SEQ_TILES;
    assign qi_last   = ({1'b0, qi_q} == seq_q - TW'(1));
    // Causal mode stops at the diagonal; otherwise the last k tile is the last sequence tile.
    assign kj_last   = causal_q ? (kj_q == qi_q) : ({1'b0, kj_q} == seq_q - TW'(1));
    assign dk_last   = (dk_q == DKW'(DK_TILES - 1));
    assign row_last  = (row_q == RW'(SA - 1));

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state_q    <= StIdle;
            sa_op_q    <= OP_QK;
            seq_q      <= '0;
            causal_q   <= 1'b0;
            qi_q       <= '0;
            kj_q       <= '0;
            dk_q       <= '0;
            row_q      <= '0;
            m_dim_q    <= MDIM_QK;
            sa_start_q <= 1'b0;
            sm_start_q <= 1'b0;
            wb_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sa_start_q <= 1'b0;
            wb_vld_q   <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (I_ATTN_START) begin
                        seq_q    <= seq_clamp;
                        causal_q <= I_CAUSAL;
                        qi_q     <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StClrMl;
                    end
                end
                StClrMl: begin
                    kj_q <= '0;
                    dk_q <= '0;
                    if (seq_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        sa_start_q <= 1'b1;
                        sa_op_q    <= OP_QK;
                        m_dim_q    <= MDIM_QK;
                        state_q    <= StQkIss;
                    end
                end
                StQkIss: state_q <= StQkWt;
                StQkWt: begin
                    if (I_SA_VLD) begin
                        sa_start_q <= 1'b1;
                        sa_op_q    <= OP_SCALE;
                        m_dim_q    <= MDIM_SA;
                        state_q    <= StScIss;
                    end
                end
                StScIss: state_q <= StScWt;
                StScWt: begin
                    if (I_SA_VLD) begin
                        row_q      <= '0;
                        sm_start_q <= 1'b1;
                        state_q    <= StSmRun;
                    end
                end
                StSmRun: begin
                    if (I_SM_VLD) begin
                        if (row_last) begin
                            sm_start_q <= 1'b0;
                            dk_q       <= '0;
                            sa_start_q <= 1'b1;
                            sa_op_q    <= OP_PV;
                            m_dim_q    <= MDIM_SA;
                            state_q    <= StPvIss;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                StPvIss: state_q <= StPvWt;
                StPvWt: begin
                    if (I_SA_VLD) begin
                        if (!dk_last) begin
                            dk_q       <= dk_q + 1'b1;
                            sa_start_q <= 1'b1;
                            state_q    <= StPvIss;
                        end else if (kj_last) begin
                            dk_q     <= '0;
                            wb_vld_q <= 1'b1;
                            state_q  <= StWb;
                        end else begin
                            kj_q       <= kj_q + 1'b1;
                            sa_start_q <= 1'b1;
                            sa_op_q    <= OP_QK;
                            m_dim_q    <= MDIM_QK;
                            state_q    <= StQkIss;
                        end
                    end
                end
                StWb: begin
                    if (!dk_last) begin
                        dk_q     <= dk_q + 1'b1;
                        wb_vld_q <= 1'b1;
                    end else if (qi_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        qi_q    <= qi_q + 1'b1;
                        state_q <= StClrMl;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    attn_ml_regfile #(
        .SA  (SA),
        .M_W (M_W),
        .L_W (L_W)
    ) u_ml (
        .clk  (I_CLK),
        .rst  (I_ASYN_RST),
        .clr  (state_q == StClrMl),
        .we   ((state_q == StSmRun) && I_SM_VLD),
        .row  (row_q),
        .m_wr (I_SM_M_OUT),
        .l_wr (I_SM_L_OUT),
        .m_rd (O_SM_M_IN),
        .l_rd (O_SM_L_IN)
    );

    assign O_SA_START   = sa_start_q;
    assign O_SA_OP      = sa_op_q;
    assign O_SA_Q_TILE  = qi_q;
    assign O_SA_K_TILE  = kj_q;
    assign O_SA_DK_TILE = dk_q;
    assign O_SA_ACC     = (kj_q != '0);
    assign O_M_DIM      = m_dim_q;
    assign O_SM_START   = sm_start_q;
    assign O_SM_ROW     = row_q;
    assign O_WB_VLD     = wb_vld_q;
    assign O_BUSY       = busy_q;
    assign O_DONE       = done_q;

endmodule
